// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder
//   Memory-side responder for the LC-3 MAR/MDR bus. Serves read/write
//   requests with a fixed number of wait states and a one-cycle memRDY
//   pulse. Accesses go to a word-addressed RAM or to the memory-mapped
//   device registers (KBSR/KBDR/DSR/DDR/MCR).
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   mem_en, mem_we    access request (level, held until memRDY) and write select
//   addr, wdata       MAR / MDR values, stable while mem_en is high
//   rdata, memRDY     registered read data and completion pulse
//   kb_valid, kb_data keyboard character strobe and character
//   kb_ready          keyboard buffer empty (~KBSR[15])
//   dd_valid, dd_data display character pending and character
//   dd_ready          display accepts the pending character
//   run               MCR[15], machine clock enable
//   int_req           keyboard or display interrupt request
module lc3_mem_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        memRDY,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        dd_valid,
    output logic [7:0]  dd_data,
    input  logic        dd_ready,
    output logic        run,
    output logic        int_req
);

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

    state_t      state;
    logic [3:0]  waitCnt;
    logic [15:0] addrQ;
    logic [15:0] wdataQ;
    logic        weQ;

    logic        kbFull;
    logic        kbIe;
    logic [7:0]  kbuf;
    logic        dsrIe;
    logic        ddValid;
    logic [7:0]  ddData;
    logic        mcrRun;

    logic [15:0] ram [2**ADDR_BITS];

    logic [15:0] accAddr;
    logic [15:0] readMux;
    logic        enterReady;
    logic        commit;
    logic        kbdrRead;

    // With zero wait states READY is entered on the same edge that latches
    // the request, so the read mux must look at the live address in IDLE.
    assign accAddr    = (state == IDLE) ? addr : addrQ;
    assign enterReady = ((state == IDLE) && mem_en && (WAIT_CYCLES == 0)) ||
                        ((state == WAIT) && (waitCnt == 4'd0));
    // A write lands on the edge leaving READY, and only if the initiator
    // still holds the write request at that edge.
    assign commit     = (state == READY) && weQ && mem_en && mem_we;
    assign kbdrRead   = (state == READY) && !weQ && (addrQ == KBDR_ADDR);

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        readMux = 16'h0000;
        if (accAddr < KBSR_ADDR) begin
            readMux = ram[accAddr[ADDR_BITS-1:0]];
        end else begin
            case (accAddr)
                KBSR_ADDR: readMux = {kbFull, kbIe, 14'h0000};
                KBDR_ADDR: readMux = {8'h00, kbuf};
                DSR_ADDR:  readMux = {~ddValid, dsrIe, 14'h0000};
                DDR_ADDR:  readMux = {8'h00, ddData};
                MCR_ADDR:  readMux = {mcrRun, 15'h0000};
                default:   readMux = 16'h0000;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            waitCnt <= 4'd0;
            addrQ   <= 16'h0000;
            wdataQ  <= 16'h0000;
            weQ     <= 1'b0;
            memRDY  <= 1'b0;
            rdata   <= 16'h0000;
        end else begin
            memRDY <= enterReady;
            if (enterReady) rdata <= readMux;
            case (state)
                IDLE: begin
                    if (mem_en) begin
                        addrQ  <= addr;
                        wdataQ <= wdata;
                        weQ    <= mem_we;
                        if (WAIT_CYCLES == 0) begin
                            state <= READY;
                        end else begin
                            waitCnt <= WAIT_LOAD;
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (waitCnt == 4'd0) state <= READY;
                    else                 waitCnt <= waitCnt - 4'd1;
                end
                READY:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Device registers. Later assignments win: a KBDR read clears the
    // buffer-full flag over a same-edge keystroke, and a DDR write keeps
    // dd_valid set over a same-edge display handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kbFull  <= 1'b0;
            kbIe    <= 1'b0;
            kbuf    <= 8'h00;
            dsrIe   <= 1'b0;
            ddValid <= 1'b0;
            ddData  <= 8'h00;
            mcrRun  <= 1'b1;
        end else begin
            if (kb_valid && !kbFull) begin
                kbuf   <= kb_data;
                kbFull <= 1'b1;
            end
            if (kbdrRead) kbFull <= 1'b0;
            if (ddValid && dd_ready) ddValid <= 1'b0;
            if (commit) begin
                case (addrQ)
                    KBSR_ADDR: kbIe  <= wdataQ[14];
                    DSR_ADDR:  dsrIe <= wdataQ[14];
                    DDR_ADDR: begin
                        ddData  <= wdataQ[7:0];
                        ddValid <= 1'b1;
                    end
                    MCR_ADDR:  mcrRun <= wdataQ[15];
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the RAM array has no reset; clearing it would cost a write port
    // per word and software never relies on its power-up contents.
    always_ff @(posedge clk) begin
        if (commit && (addrQ < KBSR_ADDR)) ram[addrQ[ADDR_BITS-1:0]] <= wdataQ;
    end

    assign kb_ready = ~kbFull;
    assign dd_valid = ddValid;
    assign dd_data  = ddData;
    assign run      = mcrRun;
    assign int_req  = (kbFull & kbIe) | (~ddValid & dsrIe);

endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb_lc3_mem_responder
//   Two responders share clk/rst: index 0 has zero wait states, index 1 has
//   two. Each access pushes its expected latency and read data onto a
//   scoreboard queue; the entry is popped when memRDY appears.
module tb_lc3_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        memEn    [2];
    logic        memWe    [2];
    logic [15:0] addrS    [2];
    logic [15:0] wdataS   [2];
    logic [15:0] rdataS   [2];
    logic        memRdyS  [2];
    logic        kbValid  [2];
    logic [7:0]  kbData   [2];
    logic        kbReady  [2];
    logic        ddValidS [2];
    logic [7:0]  ddDataS  [2];
    logic        ddReady  [2];
    logic        runS     [2];
    logic        intReq   [2];

    int tests    = 0;
    int failures = 0;

    typedef struct {
        logic        isRead;
        logic [15:0] data;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int          sel;
        logic        we;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    lc3_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .mem_en(memEn[0]), .mem_we(memWe[0]),
        .addr(addrS[0]), .wdata(wdataS[0]), .rdata(rdataS[0]), .memRDY(memRdyS[0]),
        .kb_valid(kbValid[0]), .kb_data(kbData[0]), .kb_ready(kbReady[0]),
        .dd_valid(ddValidS[0]), .dd_data(ddDataS[0]), .dd_ready(ddReady[0]),
        .run(runS[0]), .int_req(intReq[0])
    );

    lc3_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2)) u_dut1 (
        .clk(clk), .rst(rst), .mem_en(memEn[1]), .mem_we(memWe[1]),
        .addr(addrS[1]), .wdata(wdataS[1]), .rdata(rdataS[1]), .memRDY(memRdyS[1]),
        .kb_valid(kbValid[1]), .kb_data(kbData[1]), .kb_ready(kbReady[1]),
        .dd_valid(ddValidS[1]), .dd_data(ddDataS[1]), .dd_ready(ddReady[1]),
        .run(runS[1]), .int_req(intReq[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: plain access; 1: raise dd_ready during READY; 2: drop mem_en during READY
    task automatic access(input int sel, input logic we, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] expData, input int mode);
        exp_t e;
        int   n;
        bit   seen;
        e.isRead = !we;
        e.data   = expData;
        e.lat    = (sel == 0) ? 1 : 3;
        sbq.push_back(e);
        memEn[sel]  = 1'b1;
        memWe[sel]  = we;
        addrS[sel]  = a;
        wdataS[sel] = d;
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (memRdyS[sel]) seen = 1;
        end
        e = sbq.pop_front();
        if (!seen) begin
            check($sformatf("memRDY timeout dut%0d addr %h", sel, a), 32'd0, 32'd1);
        end else begin
            check($sformatf("latency dut%0d addr %h", sel, a), n, e.lat);
            if (e.isRead) check($sformatf("rdata dut%0d addr %h", sel, a), rdataS[sel], e.data);
        end
        if (mode == 1) ddReady[sel] = 1'b1;
        if (mode == 2) memEn[sel] = 1'b0;
        tick();
        memEn[sel]   = 1'b0;
        memWe[sel]   = 1'b0;
        ddReady[sel] = 1'b0;
        if (seen) check($sformatf("memRDY single pulse dut%0d addr %h", sel, a), memRdyS[sel], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        bit   sawRdy;

        vecs[0]  = '{1, 1'b1, 16'h3000, 16'h1234, 16'h0000};
        vecs[1]  = '{1, 1'b0, 16'h3000, 16'h0000, 16'h1234};
        vecs[2]  = '{0, 1'b1, 16'h0005, 16'hBEEF, 16'h0000};
        vecs[3]  = '{0, 1'b0, 16'h0405, 16'h0000, 16'hBEEF};
        vecs[4]  = '{1, 1'b0, 16'hFE00, 16'h0000, 16'h0000};
        vecs[5]  = '{1, 1'b0, 16'hFE04, 16'h0000, 16'h8000};
        vecs[6]  = '{1, 1'b0, 16'hFFFE, 16'h0000, 16'h8000};
        vecs[7]  = '{1, 1'b1, 16'hFE10, 16'h1111, 16'h0000};
        vecs[8]  = '{1, 1'b0, 16'hFE10, 16'h0000, 16'h0000};
        vecs[9]  = '{1, 1'b1, 16'hFE02, 16'h00AA, 16'h0000};
        vecs[10] = '{1, 1'b0, 16'hFE02, 16'h0000, 16'h0000};
        vecs[11] = '{1, 1'b1, 16'hFDFF, 16'h7777, 16'h0000};
        vecs[12] = '{1, 1'b0, 16'hFDFF, 16'h0000, 16'h7777};

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            memEn[i] = 1'b0; memWe[i] = 1'b0; addrS[i] = 16'h0; wdataS[i] = 16'h0;
            kbValid[i] = 1'b0; kbData[i] = 8'h00; ddReady[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset memRDY dut%0d", i), memRdyS[i], 1'b0);
            check($sformatf("reset rdata dut%0d", i), rdataS[i], 16'h0000);
            check($sformatf("reset kb_ready dut%0d", i), kbReady[i], 1'b1);
            check($sformatf("reset run dut%0d", i), runS[i], 1'b1);
            check($sformatf("reset int_req dut%0d", i), intReq[i], 1'b0);
            check($sformatf("reset dd_valid dut%0d", i), ddValidS[i], 1'b0);
        end

        for (int i = 0; i < 13; i++)
            access(vecs[i].sel, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].exp, 0);

        // Keyboard: capture, drop a second strobe while full, interrupt, read-clear.
        kbValid[1] = 1'b1; kbData[1] = 8'h41;
        tick();
        kbValid[1] = 1'b0;
        check("kb_ready after strobe", kbReady[1], 1'b0);
        kbValid[1] = 1'b1; kbData[1] = 8'h42;
        tick();
        kbValid[1] = 1'b0;
        access(1, 1'b0, 16'hFE00, 16'h0, 16'h8000, 0);
        access(1, 1'b1, 16'hFE00, 16'h4000, 16'h0, 0);
        check("int_req kb IE", intReq[1], 1'b1);
        access(1, 1'b0, 16'hFE02, 16'h0, 16'h0041, 0);
        check("kb_ready after KBDR read", kbReady[1], 1'b1);
        check("int_req after KBDR read", intReq[1], 1'b0);
        access(1, 1'b0, 16'hFE00, 16'h0, 16'h4000, 0);

        // Display: write, status, handshake.
        access(1, 1'b1, 16'hFE06, 16'h0058, 16'h0, 0);
        check("dd_valid after DDR write", ddValidS[1], 1'b1);
        check("dd_data after DDR write", ddDataS[1], 8'h58);
        access(1, 1'b0, 16'hFE04, 16'h0, 16'h0000, 0);
        ddReady[1] = 1'b1;
        tick();
        ddReady[1] = 1'b0;
        check("dd_valid after dd_ready", ddValidS[1], 1'b0);
        access(1, 1'b0, 16'hFE04, 16'h0, 16'h8000, 0);
        access(1, 1'b0, 16'hFE06, 16'h0, 16'h0058, 0);

        // DDR write commit and dd_ready on the same edge: the write wins.
        access(1, 1'b1, 16'hFE06, 16'h0059, 16'h0, 0);
        access(1, 1'b1, 16'hFE06, 16'h005A, 16'h0, 1);
        check("dd_valid write beats ready", ddValidS[1], 1'b1);
        check("dd_data write beats ready", ddDataS[1], 8'h5A);

        // Display interrupt enable.
        access(1, 1'b1, 16'hFE04, 16'h4000, 16'h0, 0);
        check("int_req display busy", intReq[1], 1'b0);
        ddReady[1] = 1'b1;
        tick();
        ddReady[1] = 1'b0;
        check("int_req display ready", intReq[1], 1'b1);
        access(1, 1'b0, 16'hFE04, 16'h0, 16'hC000, 0);
        access(1, 1'b1, 16'hFE04, 16'h0000, 16'h0, 0);
        check("int_req display IE off", intReq[1], 1'b0);

        // Machine control register.
        access(1, 1'b1, 16'hFFFE, 16'h0000, 16'h0, 0);
        check("run after MCR clear", runS[1], 1'b0);
        access(1, 1'b1, 16'hFFFE, 16'h8000, 16'h0, 0);
        check("run after MCR set", runS[1], 1'b1);

        // Write dropped when mem_en falls during READY.
        access(1, 1'b1, 16'h3002, 16'h1111, 16'h0, 0);
        access(1, 1'b1, 16'h3002, 16'h9999, 16'h0, 2);
        access(1, 1'b0, 16'h3002, 16'h0, 16'h1111, 0);

        // Reset in the middle of a write's wait states.
        access(1, 1'b1, 16'h3001, 16'h2222, 16'h0, 0);
        access(1, 1'b1, 16'hFFFE, 16'h0000, 16'h0, 0);
        access(1, 1'b1, 16'hFE06, 16'h0077, 16'h0, 0);
        kbValid[1] = 1'b1; kbData[1] = 8'h55;
        tick();
        kbValid[1] = 1'b0;
        memEn[1] = 1'b1; memWe[1] = 1'b1; addrS[1] = 16'h3001; wdataS[1] = 16'h5555;
        sawRdy = 0;
        tick();
        if (memRdyS[1]) sawRdy = 1;
        tick();
        if (memRdyS[1]) sawRdy = 1;
        rst = 1'b1;
        #2;
        memEn[1] = 1'b0; memWe[1] = 1'b0;
        tick();
        if (memRdyS[1]) sawRdy = 1;
        rst = 1'b0;
        check("rdata after mid-access reset", rdataS[1], 16'h0000);
        check("run after mid-access reset", runS[1], 1'b1);
        check("kb_ready after mid-access reset", kbReady[1], 1'b1);
        check("dd_valid after mid-access reset", ddValidS[1], 1'b0);
        check("dd_data after mid-access reset", ddDataS[1], 8'h00);
        check("int_req after mid-access reset", intReq[1], 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (memRdyS[1]) sawRdy = 1;
        end
        check("memRDY never pulses across reset", sawRdy, 1'b0);
        access(1, 1'b0, 16'h3001, 16'h0, 16'h2222, 0);
        access(1, 1'b0, 16'hFE00, 16'h0, 16'h0000, 0);
        access(1, 1'b0, 16'hFE02, 16'h0, 16'h0000, 0);
        access(1, 1'b0, 16'hFE04, 16'h0, 16'h8000, 0);
        access(1, 1'b0, 16'hFFFE, 16'h0, 16'h8000, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/lc3_mem_responder.md
# lc3_mem_responder

Memory-side responder for the LC-3 datapath's MAR/MDR bus. It answers control-unit read/write requests with a configurable wait-state `memRDY` handshake, backs them with a word-addressed RAM, and decodes the LC-3 memory-mapped device registers (KBSR/KBDR/DSR/DDR/MCR). It drives keyboard/display interrupt requests back toward the control unit's `INT` input.

## Interface
Parameters:
- `ADDR_BITS`, 10: RAM depth is 2^ADDR_BITS words, 16 bits each.
- `WAIT_CYCLES`, 2: extra wait states per access, range 0–15.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `mem_en` in 1: access request, level. Held by the initiator until `memRDY` is seen.
- `mem_we` in 1: 1 = write, 0 = read. Qualified by `mem_en`.
- `addr` in 16: MAR value, stable while `mem_en` is high.
- `wdata` in 16: MDR value, stable while `mem_en` is high.
- `rdata` out 16: read data, valid while `memRDY` is high.
- `memRDY` out 1: single-cycle completion pulse.
- `kb_valid` in 1: keyboard character strobe.
- `kb_data` in 8: keyboard character.
- `kb_ready` out 1: equals ~KBSR[15].
- `dd_valid` out 1: display character pending.
- `dd_data` out 8: display character.
- `dd_ready` in 1: display accepts the character.
- `run` out 1: MCR[15], the machine clock enable.
- `int_req` out 1: (KBSR[15]&KBSR[14]) | (DSR[15]&DSR[14]).

## Operation
- FSM states are IDLE, WAIT and READY.
  - IDLE: if `mem_en`=1, latch `addr`, `wdata` and `mem_we`. If WAIT_CYCLES=0 go to READY, otherwise load counter = WAIT_CYCLES−1 and go to WAIT.
  - WAIT: decrement the counter. At 0, go to READY.
  - READY: `memRDY`=1 for this one cycle, then return to IDLE unconditionally.
- `memRDY` and `rdata` are registered. `rdata` is loaded on the edge that enters READY.
- A write commits on the edge that leaves READY, but only if `mem_en` and `mem_we` are still high. Otherwise the write is dropped.
- Address decode uses the latched address:
  - xFE00 KBSR: bit15 ready (read-only), bit14 IE (read/write).
  - xFE02 KBDR: {8'h00, kbuf}. Read completion clears KBSR[15]. Writes are ignored.
  - xFE04 DSR: bit15 = ~dd_valid (read-only), bit14 IE (read/write).
  - xFE06 DDR: a write loads `dd_data` = wdata[7:0] and sets `dd_valid`. Reads return {8'h00, dd_data}.
  - xFFFE MCR: bit15 drives `run`. The other bits read as 0.
  - Other addresses ≥ xFE00 read as x0000. Writes to them are ignored.
  - Addresses < xFE00 go to RAM at index addr[ADDR_BITS-1:0], aliasing.
- Unused status bits read as 0.
- Keyboard: when `kb_valid` & `kb_ready`, set kbuf = `kb_data` and KBSR[15]=1. `kb_valid` while KBSR[15]=1 is dropped.
- Display: `dd_valid` clears on `dd_valid`&`dd_ready`. A DDR write while `dd_valid`=1 overwrites `dd_data`, and `dd_valid` stays 1.

## Timing
- Latency: with `mem_en` first sampled high at edge k, `memRDY` is high in cycle k+1+WAIT_CYCLES.
- The earliest next request is sampled one edge after READY, so a back-to-back access costs 2+WAIT_CYCLES cycles.
- Reset values:
  - FSM = IDLE, counter 0, `memRDY`=0, `rdata`=x0000.
  - KBSR=x0000, kbuf=x00, DSR IE=0, `dd_valid`=0, `dd_data`=x00.
  - MCR=x8000, so `run`=1. `kb_ready`=1, `int_req`=0.
  - RAM contents are not reset.
- Reset mid-access: the FSM goes to IDLE immediately and no write commits. The initiator must re-request.
- Simultaneous events:
  - KBDR read completion and `kb_valid` in the same cycle: the clear wins. `kb_ready` was low that cycle, so no character is lost.
  - DDR write commit and `dd_ready` handshake in the same edge: the write wins and `dd_valid` stays 1 with the new data.
- `int_req` is combinational from the registered status bits.

## Test plan
- WAIT_CYCLES=2: write x1234 to x3000, then read x3000. Expect `memRDY` 3 cycles after `mem_en` in each access, and the read returns x1234.
- WAIT_CYCLES=0, ADDR_BITS=10: write xBEEF to x0005, then read x0405. Expect xBEEF (alias) and the single-cycle latency.
- Keyboard path:
  - `kb_valid` with x41: `kb_ready` drops. Read KBSR → x8000.
  - Write KBSR x4000: `int_req`=1.
  - Read KBDR → x0041: KBSR[15] clears, `int_req`=0.
- Display path: write DDR x0058. Expect `dd_valid`=1 and DSR read = x0000. Assert `dd_ready` one cycle: `dd_valid`=0 and DSR read = x8000.
- Write MCR x0000: `run`=0 after the write's READY cycle. Write x8000: `run`=1.
- Assert `rst` during WAIT of a write of x5555 to x3001. Expect `memRDY` never pulses and x3001 is unchanged. Reads of KBSR/DSR/MCR return the reset values.
